// File: rtl/fm_bus_if.sv
// Bus bundle for fm_bus_seq: speccy AY-side pins plus the shared local chip bus.
interface fm_bus_if #(
   parameter int unsigned NCHIPS = 3,
   parameter int unsigned SELW   = 3
);
   logic              aybdir;
   logic              aybc1;
   logic [7:0]        ayd_in;
   logic [7:0]        ayd_out;
   logic              ayd_oe;
   logic [7:0]        d_in;
   logic [7:0]        d_out;
   logic              d_oe;
   logic [NCHIPS-1:0] cs_n;
   logic              wr_n;
   logic              rd_n;
   logic              a0;
   logic [SELW-1:0]   sel;
   logic              busy;
   logic              ovf;

   modport master (
      output aybdir, aybc1, ayd_in, d_in,
      input  ayd_out, ayd_oe, d_out, d_oe, cs_n, wr_n, rd_n, a0, sel, busy, ovf
   );

   modport slave (
      input  aybdir, aybc1, ayd_in, d_in,
      output ayd_out, ayd_oe, d_out, d_oe, cs_n, wr_n, rd_n, a0, sel, busy, ovf
   );
endinterface

// File: rtl/fm_bus_seq.sv
// AY bus cycle decoder and timed replay sequencer for NCHIPS chips on one local bus.
// Optional macro CFG_READBACK_EN: config-mode reads return {4'hF, sel} instead of 8'hFF.
module fm_bus_seq #(
   parameter int unsigned NCHIPS     = 3,
   parameter int unsigned SELW       = 3,
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned STROBE_CYC = 8,
   parameter int unsigned HOLD_CYC   = 2
) (
   input logic        fclk,
   input logic        rst_n,
   fm_bus_if.slave    bus
);
   localparam int unsigned CW = 8;
   localparam logic [1:0] PhIdle  = 2'b00;
   localparam logic [1:0] PhRead  = 2'b01;
   localparam logic [1:0] PhWrite = 2'b10;
   localparam logic [1:0] PhLatch = 2'b11;

   typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

   logic [1:0]        sync1_q, sync2_q, phase_q, phase_d;
   logic              cfg_q, cfg_d;
   logic [SELW-1:0]   sel_q, sel_d;
   logic              ovf_q, ovf_d;
   logic              pend_vld_q, pend_vld_d, pend_a0_q, pend_a0_d, pend_rd_q, pend_rd_d;
   logic [SELW-1:0]   pend_sel_q, pend_sel_d;
   logic [7:0]        pend_data_q, pend_data_d;
   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              cmd_a0_q, cmd_a0_d, cmd_rd_q, cmd_rd_d;
   logic [SELW-1:0]   cmd_sel_q, cmd_sel_d;
   logic [7:0]        cmd_data_q, cmd_data_d;
   logic [7:0]        rd_buf_q, rd_buf_d, ayd_out_q, ayd_out_d;
   logic              ayd_oe_q, ayd_oe_d;
   logic [NCHIPS-1:0] cs_n_q, cs_n_d;
   logic              wr_n_q, wr_n_d, rd_n_q, rd_n_d, a0_q, a0_d, d_oe_q, d_oe_d;
   logic              busy_q, busy_d;
   logic [7:0]        d_out_q, d_out_d;
   logic              new_cmd, new_a0, new_rd, consume;
   logic [7:0]        rdback;

`ifdef CFG_READBACK_EN
   assign rdback = {4'hF, 4'(sel_q)};
`else
   assign rdback = 8'hFF;
`endif

   always_comb begin
      phase_d     = sync2_q;
      cfg_d       = cfg_q;
      sel_d       = sel_q;
      ovf_d       = ovf_q;
      pend_vld_d  = pend_vld_q;
      pend_a0_d   = pend_a0_q;
      pend_rd_d   = pend_rd_q;
      pend_sel_d  = pend_sel_q;
      pend_data_d = pend_data_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_a0_d    = cmd_a0_q;
      cmd_rd_d    = cmd_rd_q;
      cmd_sel_d   = cmd_sel_q;
      cmd_data_d  = cmd_data_q;
      rd_buf_d    = rd_buf_q;
      ayd_out_d   = ayd_out_q;
      new_cmd     = 1'b0;
      new_a0      = 1'b0;
      new_rd      = 1'b0;

      // Commands fire only on the cycle the decoded phase changes.
      if (phase_d != phase_q) begin
         unique case (phase_d)
            PhLatch: begin
               if (bus.ayd_in[7:4] == 4'hF) begin
                  cfg_d = 1'b1;
                  if (32'(bus.ayd_in[SELW-1:0]) < NCHIPS) sel_d = bus.ayd_in[SELW-1:0];
               end else begin
                  cfg_d   = 1'b0;
                  new_cmd = 1'b1;
               end
            end
            PhWrite: begin
               new_cmd = !cfg_q;
               new_a0  = 1'b1;
            end
            PhRead: begin
               if (cfg_q) begin
                  ayd_out_d = rdback;
               end else begin
                  new_cmd   = 1'b1;
                  new_a0    = 1'b1;
                  new_rd    = 1'b1;
                  ayd_out_d = rd_buf_q;
               end
            end
            default: ;
         endcase
      end

      consume = (state_q == StIdle) && pend_vld_q;

      unique case (state_q)
         StIdle: begin
            if (pend_vld_q) begin
               state_d    = StSetup;
               cnt_d      = CW'(SETUP_CYC - 1);
               cmd_a0_d   = pend_a0_q;
               cmd_rd_d   = pend_rd_q;
               cmd_sel_d  = pend_sel_q;
               cmd_data_d = pend_data_q;
               pend_vld_d = 1'b0;
            end
         end
         StSetup: begin
            if (cnt_q == '0) begin
               state_d = StStrobe;
               cnt_d   = CW'(STROBE_CYC - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StStrobe: begin
            if (cnt_q == '0) begin
               state_d = StHold;
               cnt_d   = CW'(HOLD_CYC - 1);
               if (cmd_rd_q) begin
                  rd_buf_d  = bus.d_in;
                  ayd_out_d = bus.d_in;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StHold: begin
            if (cnt_q == '0) state_d = StIdle;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = StIdle;
      endcase

      // A slot being consumed this cycle counts as free.
      if (new_cmd) begin
         if (pend_vld_q && !consume) begin
            ovf_d = 1'b1;
         end else begin
            pend_vld_d  = 1'b1;
            pend_a0_d   = new_a0;
            pend_rd_d   = new_rd;
            pend_sel_d  = sel_q;
            pend_data_d = bus.ayd_in;
         end
      end

      cs_n_d  = '1;
      a0_d    = 1'b0;
      d_oe_d  = 1'b0;
      d_out_d = 8'h00;
      wr_n_d  = 1'b1;
      rd_n_d  = 1'b1;
      busy_d  = (state_d != StIdle);
      if (busy_d) begin
         for (int unsigned i = 0; i < NCHIPS; i++) begin
            if (cmd_sel_d == SELW'(i)) cs_n_d[i] = 1'b0;
         end
         a0_d = cmd_a0_d;
         if (!cmd_rd_d) begin
            d_oe_d  = 1'b1;
            d_out_d = cmd_data_d;
         end
         if (state_d == StStrobe) begin
            wr_n_d = cmd_rd_d;
            rd_n_d = !cmd_rd_d;
         end
      end
      ayd_oe_d = (phase_d == PhRead);
   end

   always_ff @(posedge fclk) begin
      if (!rst_n) begin
         sync1_q     <= PhIdle;
         sync2_q     <= PhIdle;
         phase_q     <= PhIdle;
         cfg_q       <= 1'b0;
         sel_q       <= '0;
         ovf_q       <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_a0_q   <= 1'b0;
         pend_rd_q   <= 1'b0;
         pend_sel_q  <= '0;
         pend_data_q <= 8'h00;
         state_q     <= StIdle;
         cnt_q       <= '0;
         cmd_a0_q    <= 1'b0;
         cmd_rd_q    <= 1'b0;
         cmd_sel_q   <= '0;
         cmd_data_q  <= 8'h00;
         rd_buf_q    <= 8'hFF;
         ayd_out_q   <= 8'hFF;
         ayd_oe_q    <= 1'b0;
         cs_n_q      <= '1;
         wr_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         a0_q        <= 1'b0;
         d_oe_q      <= 1'b0;
         d_out_q     <= 8'h00;
         busy_q      <= 1'b0;
      end else begin
         sync1_q     <= {bus.aybdir, bus.aybc1};
         sync2_q     <= sync1_q;
         phase_q     <= phase_d;
         cfg_q       <= cfg_d;
         sel_q       <= sel_d;
         ovf_q       <= ovf_d;
         pend_vld_q  <= pend_vld_d;
         pend_a0_q   <= pend_a0_d;
         pend_rd_q   <= pend_rd_d;
         pend_sel_q  <= pend_sel_d;
         pend_data_q <= pend_data_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_a0_q    <= cmd_a0_d;
         cmd_rd_q    <= cmd_rd_d;
         cmd_sel_q   <= cmd_sel_d;
         cmd_data_q  <= cmd_data_d;
         rd_buf_q    <= rd_buf_d;
         ayd_out_q   <= ayd_out_d;
         ayd_oe_q    <= ayd_oe_d;
         cs_n_q      <= cs_n_d;
         wr_n_q      <= wr_n_d;
         rd_n_q      <= rd_n_d;
         a0_q        <= a0_d;
         d_oe_q      <= d_oe_d;
         d_out_q     <= d_out_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.ayd_out = ayd_out_q;
   assign bus.ayd_oe  = ayd_oe_q;
   assign bus.d_out   = d_out_q;
   assign bus.d_oe    = d_oe_q;
   assign bus.cs_n    = cs_n_q;
   assign bus.wr_n    = wr_n_q;
   assign bus.rd_n    = rd_n_q;
   assign bus.a0      = a0_q;
   assign bus.sel     = sel_q;
   assign bus.busy    = busy_q;
   assign bus.ovf     = ovf_q;
endmodule
